// File: rtl/mem_sum_controller.sv
// mem_sum_controller
//
// Sequencer between the debounced front-panel buttons, a 2-read/1-write
// register-file memory and the display. One FSM (IDLE / WRITE / SUM) handles
// browsing with next/prev, writing switch data, and a reduce-sum of all
// DEPTH = 2**AW entries, two entries per cycle through both read ports.
//
// Parameters
//   AW  address width, DEPTH = 2**AW entries (AW >= 2)
//   DW  data width
//   SW  sum width, must be >= DW+AW so the total cannot overflow
//
// Ports
//   clk, reset                      clock (rising edge), async active-high reset
//   prev_btn, next_btn              browse requests (previous / next address)
//   enter_btn                       write input_data at input_addr
//   sum_btn                         start reduce-sum
//   input_addr, input_data          switch address / data for enter
//   rd_data1, rd_data2              memory read data (combinational of rd_addr1/2)
//   wr_en, wr_addr, wr_data         memory write port, wr_en high only in WRITE
//   rd_addr1, rd_addr2              memory read addresses
//   disp_addr, disp_data            address being shown and its registered data
//   sum_out, sum_valid              last completed sum, one-cycle update strobe
//   busy                            high whenever the FSM is not in IDLE
//   state_dbg                       current FSM state encoding (0 IDLE, 1 WRITE, 2 SUM)
//
// Build option
//   MSC_EDGE_DETECT_EN  when defined, every *_btn input passes through a
//                       registered rising-edge detector, so a held level is a
//                       single request (one extra cycle of request latency).
//                       When undefined, *_btn are used directly as pulses.
//
// Result interface: sum_valid is a one-cycle strobe with no backpressure.
// sum_out changes only on the edge that raises sum_valid and is stable until
// the next strobe or reset. Requests are only looked at in IDLE; requests
// arriving in WRITE or SUM are dropped, never queued.

module mem_sum_controller #(
    parameter int AW = 4,
    parameter int DW = 8,
    parameter int SW = 12
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          prev_btn,
    input  logic          next_btn,
    input  logic          enter_btn,
    input  logic          sum_btn,
    input  logic [AW-1:0] input_addr,
    input  logic [DW-1:0] input_data,
    input  logic [DW-1:0] rd_data1,
    input  logic [DW-1:0] rd_data2,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [DW-1:0] wr_data,
    output logic [AW-1:0] rd_addr1,
    output logic [AW-1:0] rd_addr2,
    output logic [AW-1:0] disp_addr,
    output logic [DW-1:0] disp_data,
    output logic [SW-1:0] sum_out,
    output logic          sum_valid,
    output logic          busy,
    output logic [1:0]    state_dbg
);

    localparam int DEPTH = 1 << AW;
    // Last pair index of the sum: pairs 0 .. DEPTH/2-1
    localparam logic [AW-1:0] K_LAST = AW'(DEPTH / 2 - 1);

    generate
        if (SW < DW + AW) begin : g_bad_sw
            $error("mem_sum_controller: SW must be >= DW+AW");
        end
        if (AW < 2) begin : g_bad_aw
            $error("mem_sum_controller: AW must be >= 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_SUM   = 2'd2
    } state_t;

    // Request vector: [3]=enter, [2]=sum, [1]=next, [0]=prev
    logic [3:0] btn_now;
    logic [3:0] req;

    assign btn_now = {enter_btn, sum_btn, next_btn, prev_btn};

`ifdef MSC_EDGE_DETECT_EN
    logic [3:0] btn_d;
    logic [3:0] req_r;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_d <= '0;
            req_r <= '0;
        end else begin
            btn_d <= btn_now;
            req_r <= btn_now & ~btn_d;
        end
    end

    assign req = req_r;
`else
    assign req = btn_now;
`endif

    state_t        state_q, state_n;
    logic [AW-1:0] cur_q, cur_n;
    logic [AW-1:0] k_q, k_n;
    logic [SW-1:0] acc_q, acc_n;
    logic [AW-1:0] wr_addr_q, wr_addr_n;
    logic [DW-1:0] wr_data_q, wr_data_n;
    logic          wr_en_q, wr_en_n;
    logic [DW-1:0] disp_q, disp_n;
    logic [SW-1:0] sum_q, sum_n;
    logic          sum_valid_q, sum_valid_n;
    logic [SW-1:0] total;

    // Running total including the pair presented this cycle
    assign total = acc_q + SW'(rd_data1) + SW'(rd_data2);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cur_q       <= '0;
            k_q         <= '0;
            acc_q       <= '0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            wr_en_q     <= 1'b0;
            disp_q      <= '0;
            sum_q       <= '0;
            sum_valid_q <= 1'b0;
        end else begin
            state_q     <= state_n;
            cur_q       <= cur_n;
            k_q         <= k_n;
            acc_q       <= acc_n;
            wr_addr_q   <= wr_addr_n;
            wr_data_q   <= wr_data_n;
            wr_en_q     <= wr_en_n;
            disp_q      <= disp_n;
            sum_q       <= sum_n;
            sum_valid_q <= sum_valid_n;
        end
    end

    always_comb begin
        state_n     = state_q;
        cur_n       = cur_q;
        k_n         = k_q;
        acc_n       = acc_q;
        wr_addr_n   = wr_addr_q;
        wr_data_n   = wr_data_q;
        wr_en_n     = 1'b0;
        disp_n      = disp_q;
        sum_n       = sum_q;
        sum_valid_n = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                disp_n = rd_data1;
                if (req[3]) begin
                    wr_addr_n = input_addr;
                    wr_data_n = input_data;
                    cur_n     = input_addr;
                    // wr_en is registered so it is high exactly while in WRITE
                    wr_en_n   = 1'b1;
                    state_n   = S_WRITE;
                end else if (req[2]) begin
                    k_n     = '0;
                    acc_n   = '0;
                    state_n = S_SUM;
                end else if (req[1]) begin
                    // DEPTH is a power of two, so AW-bit arithmetic wraps
                    cur_n = cur_q + 1'b1;
                end else if (req[0]) begin
                    cur_n = cur_q - 1'b1;
                end
            end

            S_WRITE: begin
                state_n = S_IDLE;
            end

            S_SUM: begin
                if (k_q == K_LAST) begin
                    sum_n       = total;
                    sum_valid_n = 1'b1;
                    acc_n       = '0;
                    k_n         = '0;
                    state_n     = S_IDLE;
                end else begin
                    acc_n = total;
                    k_n   = k_q + 1'b1;
                end
            end

            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // Read ports follow the display address except during SUM, where they
    // walk the even/odd pair selected by k.
    always_comb begin
        rd_addr1 = cur_q;
        rd_addr2 = cur_q;
        if (state_q == S_SUM) begin
            rd_addr1 = {k_q[AW-2:0], 1'b0};
            rd_addr2 = {k_q[AW-2:0], 1'b1};
        end
    end

    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign disp_addr = cur_q;
    assign disp_data = disp_q;
    assign sum_out   = sum_q;
    assign sum_valid = sum_valid_q;
    assign busy      = (state_q != S_IDLE);
    assign state_dbg = state_q;

endmodule

// File: tb/tb_mem_sum_controller.sv
// Directed testbench for mem_sum_controller with a behavioural 2R/1W memory.

module tb_mem_sum_controller;

    localparam int AW = 4;
    localparam int DW = 8;
    localparam int SW = 12;

`ifdef MSC_EDGE_DETECT_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    logic          clk;
    logic          reset;
    logic          prev_btn, next_btn, enter_btn, sum_btn;
    logic [AW-1:0] input_addr;
    logic [DW-1:0] input_data;
    logic [DW-1:0] rd_data1, rd_data2;
    logic          wr_en;
    logic [AW-1:0] wr_addr, rd_addr1, rd_addr2, disp_addr;
    logic [DW-1:0] wr_data, disp_data;
    logic [SW-1:0] sum_out;
    logic          sum_valid, busy;
    logic [1:0]    state_dbg;

    logic [DW-1:0] mem [16];

    int n_vec;
    int n_err;
    int wr_cycles;
    int sv_cycles;
    int wr_base;
    int sv_base;
    logic [SW-1:0] exp_q[$];
    logic [SW-1:0] exp_sum;

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    mem_sum_controller #(.AW(AW), .DW(DW), .SW(SW)) dut (
        .clk        (clk),
        .reset      (reset),
        .prev_btn   (prev_btn),
        .next_btn   (next_btn),
        .enter_btn  (enter_btn),
        .sum_btn    (sum_btn),
        .input_addr (input_addr),
        .input_data (input_data),
        .rd_data1   (rd_data1),
        .rd_data2   (rd_data2),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rd_addr1   (rd_addr1),
        .rd_addr2   (rd_addr2),
        .disp_addr  (disp_addr),
        .disp_data  (disp_data),
        .sum_out    (sum_out),
        .sum_valid  (sum_valid),
        .busy       (busy),
        .state_dbg  (state_dbg)
    );

    // memory model: combinational reads, write on rising edge
    assign rd_data1 = mem[rd_addr1];
    assign rd_data2 = mem[rd_addr2];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) mem[i] <= '0;
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
        if (wr_en) wr_cycles++;
        if (sum_valid) sv_cycles++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // After these return, the FSM has sampled the request at the last edge.
    task automatic press_enter(input logic [AW-1:0] a, input logic [DW-1:0] d);
        input_addr = a;
        input_data = d;
        enter_btn  = 1'b1;
        tick();
        enter_btn  = 1'b0;
        repeat (LAT) tick();
    endtask

    task automatic press_sum();
        sum_btn = 1'b1;
        tick();
        sum_btn = 1'b0;
        repeat (LAT) tick();
    endtask

    task automatic press_next();
        next_btn = 1'b1;
        tick();
        next_btn = 1'b0;
        repeat (LAT) tick();
    endtask

    task automatic press_prev();
        prev_btn = 1'b1;
        tick();
        prev_btn = 1'b0;
        repeat (LAT) tick();
    endtask

    initial begin
        n_vec = 0; n_err = 0; wr_cycles = 0; sv_cycles = 0;
        reset = 1'b1;
        prev_btn = 1'b0; next_btn = 1'b0; enter_btn = 1'b0; sum_btn = 1'b0;
        input_addr = '0; input_data = '0;

        // ---- reset state ----
        repeat (3) tick();
        check("rst_wr_en",     32'(wr_en), 0);
        check("rst_wr_addr",   32'(wr_addr), 0);
        check("rst_wr_data",   32'(wr_data), 0);
        check("rst_rd_addr1",  32'(rd_addr1), 0);
        check("rst_rd_addr2",  32'(rd_addr2), 0);
        check("rst_disp_addr", 32'(disp_addr), 0);
        check("rst_disp_data", 32'(disp_data), 0);
        check("rst_sum_out",   32'(sum_out), 0);
        check("rst_sum_valid", 32'(sum_valid), 0);
        check("rst_busy",      32'(busy), 0);
        check("rst_state",     32'(state_dbg), 0);
        reset = 1'b0;
        tick();

        // ---- 1: reset mid-SUM ----
        sv_base = sv_cycles;
        press_sum();
        check("sum_busy", 32'(busy), 1);
        check("sum_state", 32'(state_dbg), 2);
        repeat (3) tick();
        check("sum_rd_addr1_k3", 32'(rd_addr1), 6);
        check("sum_rd_addr2_k3", 32'(rd_addr2), 7);
        reset = 1'b1;
        #1;
        check("abort_busy",      32'(busy), 0);
        check("abort_state",     32'(state_dbg), 0);
        check("abort_sum_valid", 32'(sum_valid), 0);
        check("abort_sum_out",   32'(sum_out), 0);
        check("abort_rd_addr1",  32'(rd_addr1), 0);
        repeat (2) tick();
        reset = 1'b0;
        repeat (12) tick();
        check("abort_no_pulse", 32'(sv_cycles - sv_base), 0);

        // ---- 2: overwrite the same address ----
        wr_base = wr_cycles;
        press_enter(4'd5, 8'hA3);
        check("w1_wr_en",   32'(wr_en), 1);
        check("w1_wr_addr", 32'(wr_addr), 5);
        check("w1_wr_data", 32'(wr_data), 32'hA3);
        check("w1_busy",    32'(busy), 1);
        tick();
        check("w1_wr_en_off", 32'(wr_en), 0);
        check("w1_mem5",      32'(mem[5]), 32'hA3);
        tick();
        check("w1_disp_addr", 32'(disp_addr), 5);
        check("w1_disp_data", 32'(disp_data), 32'hA3);
        press_enter(4'd5, 8'h11);
        check("w2_wr_en", 32'(wr_en), 1);
        tick();
        check("w2_wr_en_off", 32'(wr_en), 0);
        tick();
        check("w2_mem5",      32'(mem[5]), 32'h11);
        check("w2_disp_addr", 32'(disp_addr), 5);
        check("w2_disp_data", 32'(disp_data), 32'h11);
        check("w_en_cycles",  32'(wr_cycles - wr_base), 2);

        // ---- 3: sums of uniform memories ----
        for (int pass = 0; pass < 2; pass++) begin
            logic [DW-1:0] fill;
            fill = (pass == 0) ? 8'h33 : 8'hFF;
            for (int i = 0; i < 16; i++) begin
                press_enter(AW'(i), fill);
                tick();
            end
            exp_q.push_back((pass == 0) ? 12'h330 : 12'hFF0);
            sv_base = sv_cycles;
            press_sum();
            repeat (7) tick();
            check("sum_not_early", 32'(sum_valid), 0);
            check("sum_busy_7",    32'(busy), 1);
            tick();
            exp_sum = exp_q.pop_front();
            check("sum_valid_8", 32'(sum_valid), 1);
            check("sum_out_8",   32'(sum_out), 32'(exp_sum));
            check("sum_idle_8",  32'(busy), 0);
            tick();
            check("sum_valid_off", 32'(sum_valid), 0);
            check("sum_out_hold",  32'(sum_out), 32'(exp_sum));
            check("sum_pulses",    32'(sv_cycles - sv_base), 1);
        end

        // ---- 4: browse wrap-around (cur_addr is 15 after the fill) ----
        check("nav_start", 32'(disp_addr), 15);
        press_next();
        check("nav_next_wrap", 32'(disp_addr), 0);
        press_prev();
        check("nav_prev_wrap", 32'(disp_addr), 15);
        press_next();
        press_next();
        check("nav_at_1", 32'(disp_addr), 1);
        press_prev();
        check("nav_prev_to_0", 32'(disp_addr), 0);
        press_prev();
        check("nav_prev_to_15", 32'(disp_addr), 15);

        // ---- 5: priority and dropped requests ----
        input_addr = 4'd3;
        input_data = 8'h5A;
        enter_btn = 1'b1; sum_btn = 1'b1; next_btn = 1'b1;
        tick();
        enter_btn = 1'b0; sum_btn = 1'b0; next_btn = 1'b0;
        repeat (LAT) tick();
        check("prio_state",   32'(state_dbg), 1);
        check("prio_wr_addr", 32'(wr_addr), 3);
        check("prio_cur",     32'(disp_addr), 3);
        tick();
        check("prio_idle",      32'(busy), 0);
        check("prio_no_next",   32'(disp_addr), 3);
        check("prio_mem3",      32'(mem[3]), 32'h5A);
        // all 0xFF except mem[3]=0x5A: 0xFF0 - 0xFF + 0x5A
        exp_q.push_back(12'hF4B);
        sv_base = sv_cycles;
        press_sum();
        repeat (3) tick();
        sum_btn = 1'b1;
        tick();
        sum_btn = 1'b0;
        repeat (3) tick();
        check("drop_not_early", 32'(sum_valid), 0);
        tick();
        exp_sum = exp_q.pop_front();
        check("drop_sum_valid", 32'(sum_valid), 1);
        check("drop_sum_out",   32'(sum_out), 32'(exp_sum));
        repeat (14) tick();
        check("drop_single_pulse", 32'(sv_cycles - sv_base), 1);
        check("drop_idle",         32'(busy), 0);

        // ---- 6: held next level ----
        next_btn = 1'b1;
        repeat (10) tick();
        next_btn = 1'b0;
        repeat (LAT) tick();
`ifdef MSC_EDGE_DETECT_EN
        check("held_next", 32'(disp_addr), 4);
`else
        check("held_next", 32'(disp_addr), 13);
`endif
        tick();
        check("held_disp_data", 32'(disp_data), 32'hFF);
        check("exp_q_empty", 32'(exp_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
